// File: rtl/sata_cmd_pkg.sv
// Shared constants, FSM encoding and command record for the sata_host command sequencer.
package sata_cmd_pkg;

    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b01;
    localparam logic [1:0] ERR_ACK_TMO  = 2'b10;
    localparam logic [1:0] ERR_DONE_TMO = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CHECK    = 3'd1,
        ST_ISSUE    = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_BUSY     = 3'd4,
        ST_DONE     = 3'd5
    } seq_state_t;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] count;
        logic [31:0] addr;
    } cmd_t;

    function automatic logic cmd_legal(input logic [1:0] kind, input logic [31:0] count);
        return ((kind == CMD_READ) || (kind == CMD_WRITE)) && (count != 32'd0);
    endfunction

endpackage

// File: rtl/sata_cmd_fifo.sv
// Synchronous command FIFO with registered occupancy level and a single-cycle flush.
module sata_cmd_fifo
    import sata_cmd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       flush,
    input  logic       push,
    input  cmd_t       wdata,
    input  logic       pop,
    output cmd_t       rdata,
    output logic [4:0] level,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    cmd_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (level == 5'(DEPTH));
    assign empty   = (level == 5'd0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage carries no reset; only pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= 5'd0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= 5'd0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + 5'd1;
                2'b01:   level <= level - 5'd1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/sata_cmd_sequencer.sv
// Queues disk commands and issues them one at a time to sata_host, watching ack and completion
// with timeouts and reporting done/error per command.
module sata_cmd_sequencer
    import sata_cmd_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int ACK_TMO  = 1024,
    parameter int DONE_TMO = 2**24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_type_in,
    input  logic [31:0] cmd_count_in,
    input  logic [31:0] cmd_addr_in,
    input  logic        abort,
    input  logic        ready_for_cmd,
    output logic        new_cmd,
    output logic [1:0]  cmd_type,
    output logic [31:0] sector_count,
    output logic [31:0] sector_addr,
    output logic        busy,
    output logic        done_pulse,
    output logic        err_pulse,
    output logic [1:0]  err_code,
    output logic [15:0] done_cnt,
    output logic [4:0]  q_level,
    output logic [2:0]  fsm_state
);

    // Handshakes: a command is pushed on any clock edge where cmd_valid && cmd_ready
    // (and abort is low); sata_host accepts a command via the one-cycle new_cmd strobe
    // while ready_for_cmd is high, acknowledges by dropping it, and completes by raising it.

    localparam logic [23:0] ACK_LIM  = 24'(ACK_TMO - 1);
    localparam logic [23:0] DONE_LIM = 24'(DONE_TMO - 1);

    seq_state_t  state;
    seq_state_t  state_next;
    logic [23:0] timer;
    logic        timer_clr;
    logic        load_cmd;
    logic        clear_cmd;
    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    cmd_t        fifo_wdata;
    cmd_t        fifo_head;

    assign fifo_wdata = {cmd_type_in, cmd_count_in, cmd_addr_in};
    assign fifo_push  = cmd_valid && !fifo_full && !abort;
    assign cmd_ready  = !fifo_full;
    assign busy       = (state != ST_IDLE);
    assign fsm_state  = state;

    sata_cmd_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset_n(reset_n),
        .flush  (abort),
        .push   (fifo_push),
        .wdata  (fifo_wdata),
        .pop    (fifo_pop),
        .rdata  (fifo_head),
        .level  (q_level),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        load_cmd   = 1'b0;
        clear_cmd  = 1'b0;
        timer_clr  = 1'b0;
        new_cmd    = 1'b0;
        done_pulse = 1'b0;
        err_pulse  = 1'b0;
        err_code   = ERR_NONE;
        if (abort) begin
            state_next = ST_IDLE;
            clear_cmd  = 1'b1;
            timer_clr  = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        load_cmd   = 1'b1;
                        state_next = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (!cmd_legal(cmd_type, sector_count)) begin
                        err_pulse  = 1'b1;
                        err_code   = ERR_ILLEGAL;
                        clear_cmd  = 1'b1;
                        state_next = ST_IDLE;
                    end else if (ready_for_cmd) begin
                        state_next = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    new_cmd    = 1'b1;
                    timer_clr  = 1'b1;
                    state_next = ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (!ready_for_cmd) begin
                        timer_clr  = 1'b1;
                        state_next = ST_BUSY;
                    end else if (timer == ACK_LIM) begin
                        err_pulse  = 1'b1;
                        err_code   = ERR_ACK_TMO;
                        clear_cmd  = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (ready_for_cmd) begin
                        state_next = ST_DONE;
                    end else if (timer == DONE_LIM) begin
                        err_pulse  = 1'b1;
                        err_code   = ERR_DONE_TMO;
                        clear_cmd  = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
                ST_DONE: begin
                    done_pulse = 1'b1;
                    // Chaining straight into CHECK keeps back-to-back issues 5 cycles apart.
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        load_cmd   = 1'b1;
                        state_next = ST_CHECK;
                    end else begin
                        clear_cmd  = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
                default: begin
                    clear_cmd  = 1'b1;
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer <= 24'd0;
        end else if (timer_clr) begin
            timer <= 24'd0;
        end else if (((state == ST_WAIT_ACK) || (state == ST_BUSY)) && (timer != 24'hFF_FFFF)) begin
            timer <= timer + 24'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_type     <= 2'b00;
            sector_count <= 32'd0;
            sector_addr  <= 32'd0;
        end else if (clear_cmd) begin
            cmd_type     <= 2'b00;
            sector_count <= 32'd0;
            sector_addr  <= 32'd0;
        end else if (load_cmd) begin
            cmd_type     <= fifo_head.kind;
            sector_count <= fifo_head.count;
            sector_addr  <= fifo_head.addr;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_cnt <= 16'd0;
        end else if (done_pulse) begin
            done_cnt <= done_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_sata_cmd_sequencer.sv
// Directed bench for sata_cmd_sequencer: hand-driven sata_host handshake, issue-order scoreboard.
module tb_sata_cmd_sequencer;
    import sata_cmd_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_type_in;
    logic [31:0] cmd_count_in;
    logic [31:0] cmd_addr_in;
    logic        abort;
    logic        ready_for_cmd;
    logic        new_cmd;
    logic [1:0]  cmd_type;
    logic [31:0] sector_count;
    logic [31:0] sector_addr;
    logic        busy;
    logic        done_pulse;
    logic        err_pulse;
    logic [1:0]  err_code;
    logic [15:0] done_cnt;
    logic [4:0]  q_level;
    logic [2:0]  fsm_state;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_issue  = 0;
    int          n_done   = 0;
    int          n_err    = 0;
    int          cyc      = 0;
    logic [65:0] exp_q[$];
    logic [1:0]  err_log[$];

    sata_cmd_sequencer #(
        .DEPTH   (4),
        .ACK_TMO (16),
        .DONE_TMO(64)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_type_in  (cmd_type_in),
        .cmd_count_in (cmd_count_in),
        .cmd_addr_in  (cmd_addr_in),
        .abort        (abort),
        .ready_for_cmd(ready_for_cmd),
        .new_cmd      (new_cmd),
        .cmd_type     (cmd_type),
        .sector_count (sector_count),
        .sector_addr  (sector_addr),
        .busy         (busy),
        .done_pulse   (done_pulse),
        .err_pulse    (err_pulse),
        .err_code     (err_code),
        .done_cnt     (done_cnt),
        .q_level      (q_level),
        .fsm_state    (fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout obs=running exp=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // scoreboard monitor: issue order, pulse exclusivity, pulse counts
    always @(negedge clk) begin
        if (reset_n) begin
            if (new_cmd) begin
                n_issue++;
                check("issue_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    check("issue_order", {cmd_type, sector_count, sector_addr}, exp_q.pop_front());
                end
            end
            if (done_pulse || err_pulse) begin
                check("pulse_excl", done_pulse & err_pulse, 1'b0);
            end
            if (done_pulse) n_done++;
            if (err_pulse) begin
                n_err++;
                err_log.push_back(err_code);
            end
        end
    end

    // driver tasks: all input changes happen 1 time unit after a rising edge
    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [1:0] t, input logic [31:0] n, input logic [31:0] a,
                         output logic acc);
        cmd_valid    = 1'b1;
        cmd_type_in  = t;
        cmd_count_in = n;
        cmd_addr_in  = a;
        acc          = cmd_ready && !abort;
        step();
        cmd_valid    = 1'b0;
    endtask

    task automatic wait_issue(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (new_cmd) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        check(tag, seen, 1'b1);
    endtask

    task automatic wait_done(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done_pulse) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        check(tag, seen, 1'b1);
    endtask

    task automatic wait_err(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (err_pulse) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        check(tag, seen, 1'b1);
    endtask

    // sata_host answering as fast as allowed: ack the cycle after issue, complete the cycle after that
    task automatic serve_fast(input string tag, output int issue_cyc);
        wait_issue(tag);
        issue_cyc = cyc;
        step();
        ready_for_cmd = 1'b0;
        step();
        ready_for_cmd = 1'b1;
    endtask

    initial begin
        logic acc;
        int   t_iss[4];
        int   base_issue;
        int   base_done;
        int   base_err;
        int   mark;

        reset_n       = 1'b0;
        cmd_valid     = 1'b0;
        cmd_type_in   = 2'b00;
        cmd_count_in  = 32'd0;
        cmd_addr_in   = 32'd0;
        abort         = 1'b0;
        ready_for_cmd = 1'b1;
        step(3);
        reset_n = 1'b1;
        step();

        // reset state
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_new_cmd", new_cmd, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_q_level", q_level, 5'd0);
        check("rst_done_cnt", done_cnt, 16'd0);
        check("rst_outputs", {cmd_type, sector_count, sector_addr}, 66'd0);
        check("rst_pulses", {done_pulse, err_pulse, err_code}, 4'd0);

        // 1: single READ, ack after 3 cycles, complete after 20
        exp_q.push_back({CMD_READ, 32'd8, 32'h100});
        offer(CMD_READ, 32'd8, 32'h100, acc);
        check("t1_accept", acc, 1'b1);
        wait_issue("t1_issue");
        check("t1_issue_fields", {cmd_type, sector_count, sector_addr}, {2'b01, 32'd8, 32'h100});
        step(3);
        ready_for_cmd = 1'b0;
        step(10);
        check("t1_stable_mid", {cmd_type, sector_count, sector_addr}, {2'b01, 32'd8, 32'h100});
        step(10);
        check("t1_stable_late", {cmd_type, sector_count, sector_addr}, {2'b01, 32'd8, 32'h100});
        check("t1_state_busy", fsm_state, ST_BUSY);
        ready_for_cmd = 1'b1;
        wait_done("t1_done");
        step();
        check("t1_done_cnt", done_cnt, 16'd1);
        check("t1_issue_count", n_issue, 1);
        check("t1_done_count", n_done, 1);
        check("t1_idle", busy, 1'b0);
        check("t1_outputs_zeroed", {cmd_type, sector_count, sector_addr}, 66'd0);

        // 2: fill queue behind a stalled command, then drain at full speed
        exp_q.push_back({CMD_READ, 32'd1, 32'h200});
        offer(CMD_READ, 32'd1, 32'h200, acc);
        wait_issue("t2_issue_p");
        step();
        ready_for_cmd = 1'b0;
        base_issue = n_issue;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) exp_q.push_back({CMD_WRITE, 32'(i + 1), 32'h1000 + 32'(i)});
            offer(CMD_WRITE, 32'(i + 1), 32'h1000 + 32'(i), acc);
            check($sformatf("t2_accept_%0d", i), acc, (i < 4));
        end
        check("t2_q_level_full", q_level, 5'd4);
        check("t2_cmd_ready_full", cmd_ready, 1'b0);
        check("t2_state_busy", fsm_state, ST_BUSY);
        check("t2_no_issue_stalled", n_issue, base_issue);
        ready_for_cmd = 1'b1;
        wait_done("t2_done_p");
        for (int i = 0; i < 4; i++) begin
            serve_fast($sformatf("t2_issue_%0d", i), t_iss[i]);
        end
        for (int i = 1; i < 4; i++) begin
            check($sformatf("t2_issue_gap_%0d", i), t_iss[i] - t_iss[i - 1], 5);
        end
        wait_done("t2_done_last");
        step();
        check("t2_done_cnt", done_cnt, 16'd6);
        check("t2_q_level_empty", q_level, 5'd0);
        check("t2_idle", busy, 1'b0);

        // 3: illegal type and zero count are rejected without issue
        err_log.delete();
        base_issue = n_issue;
        offer(2'b11, 32'd5, 32'h300, acc);
        offer(CMD_WRITE, 32'd0, 32'h304, acc);
        step(8);
        check("t3_err_count", err_log.size(), 2);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("t3_code_%0d", i), (i < err_log.size()) ? err_log[i] : 2'b00, 2'b01);
        end
        check("t3_no_issue", n_issue, base_issue);
        check("t3_done_cnt", done_cnt, 16'd6);

        // 4: ack timeout, 16 cycles after new_cmd
        exp_q.push_back({CMD_READ, 32'd4, 32'h400});
        offer(CMD_READ, 32'd4, 32'h400, acc);
        wait_issue("t4_issue");
        mark = cyc;
        wait_err("t4_err_seen");
        check("t4_err_delay", cyc - mark, 16);
        check("t4_err_code", err_code, 2'b10);
        step();
        check("t4_state_idle", fsm_state, ST_IDLE);
        check("t4_done_cnt", done_cnt, 16'd6);

        // 5: done timeout 64 cycles after the drop; next command waits for ready
        exp_q.push_back({CMD_READ, 32'd2, 32'h500});
        exp_q.push_back({CMD_WRITE, 32'd3, 32'h600});
        offer(CMD_READ, 32'd2, 32'h500, acc);
        offer(CMD_WRITE, 32'd3, 32'h600, acc);
        wait_issue("t5_issue_a");
        step();
        ready_for_cmd = 1'b0;
        mark = cyc;
        wait_err("t5_err_seen");
        check("t5_err_delay", cyc - mark, 64);
        check("t5_err_code", err_code, 2'b11);
        base_issue = n_issue;
        step(5);
        check("t5_state_check", fsm_state, ST_CHECK);
        check("t5_held_no_issue", n_issue, base_issue);
        check("t5_held_fields", {cmd_type, sector_count, sector_addr}, {2'b10, 32'd3, 32'h600});
        ready_for_cmd = 1'b1;
        serve_fast("t5_issue_b", mark);
        wait_done("t5_done_b");
        step();
        check("t5_done_cnt", done_cnt, 16'd7);

        // 6: abort in BUSY with 3 queued, push in abort cycle dropped
        exp_q.push_back({CMD_READ, 32'd6, 32'h800});
        offer(CMD_READ, 32'd6, 32'h800, acc);
        wait_issue("t6_issue");
        step();
        ready_for_cmd = 1'b0;
        for (int i = 0; i < 3; i++) begin
            offer(CMD_WRITE, 32'd1, 32'h880 + 32'(i), acc);
        end
        step();
        check("t6_q_level_3", q_level, 5'd3);
        check("t6_state_busy", fsm_state, ST_BUSY);
        base_done = n_done;
        base_err  = n_err;
        base_issue = n_issue;
        abort = 1'b1;
        offer(CMD_READ, 32'd7, 32'h8F0, acc);
        abort = 1'b0;
        check("t6_q_level_flushed", q_level, 5'd0);
        check("t6_busy_cleared", busy, 1'b0);
        check("t6_state_idle", fsm_state, ST_IDLE);
        check("t6_outputs_zeroed", {cmd_type, sector_count, sector_addr}, 66'd0);
        step(4);
        check("t6_no_done", n_done, base_done);
        check("t6_no_err", n_err, base_err);
        check("t6_no_reissue", n_issue, base_issue);
        check("t6_done_cnt_kept", done_cnt, 16'd7);
        ready_for_cmd = 1'b1;

        // 6b: async reset while new_cmd is high
        offer(CMD_WRITE, 32'd9, 32'h900, acc);
        wait_issue("t6_rst_issue");
        reset_n = 1'b0;
        #1;
        check("t6_rst_new_cmd", new_cmd, 1'b0);
        check("t6_rst_done_cnt", done_cnt, 16'd0);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_cmd_ready", cmd_ready, 1'b1);
        check("t6_rst_q_level", q_level, 5'd0);
        step(2);
        reset_n = 1'b1;
        step(3);
        check("t6_rst_stays_idle", busy, 1'b0);

        check("exp_q_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
